pci_arbiter: RTL
================

# pci_arbiter

Central bus arbiter for the shared PCI bus segment. Collects active-low REQ lines from up to NUM_MASTERS devices and drives one-hot active-low GNT lines with fair round-robin rotation. It monitors FRAME/IRDY to detect bus ownership and idle, so that the grant moves only at legal points. It replaces the testbench-driven GNT stimulus and sits beside the devices on the same bus.

## Interface
- NUM_MASTERS, 3: number of requesters (2..8).
- GNT_TIMEOUT, 16: clocks a granted master may leave FRAME high on an idle bus before its grant is revoked.
- IDXW, $clog2(NUM_MASTERS): width of owner index (derived, not overridable).

Ports:
- clk  in  1  bus clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- REQ  in  NUM_MASTERS  per-master request, active low.
- FRAME  in  1  bus FRAME, active low, sampled only.
- IRDY  in  1  bus IRDY, active low, sampled only.
- GNT  out  NUM_MASTERS  per-master grant, active low, at most one bit low.
- owner  out  IDXW  index of the granted master; valid when owner_valid=1.
- owner_valid  out  1  high while any GNT bit is low.
- bus_idle  out  1  registered, FRAME=1 and IRDY=1 at last posedge.
- timeout  out  1  one-clock pulse when a grant is revoked by GNT_TIMEOUT.

## Operation
- Reset values: GNT all ones, owner 0, owner_valid 0, bus_idle 1, timeout 0, state IDLE, last_owner NUM_MASTERS-1, timer 0.
- Reset asserted mid-operation: all GNT high immediately and asynchronously. No transaction is completed.
- Round-robin pick: first index with REQ=0, searching last_owner+1, +2, … with wrap modulo NUM_MASTERS. last_owner updates on each new grant.
- The state machine has four states: IDLE, GRANTED, OWNED and TURN.
- IDLE: if any REQ=0, assert GNT[pick], set owner, clear timer, go to GRANTED. Otherwise stay in IDLE.
- GRANTED: FRAME=0 goes to OWNED.
  - Otherwise, REQ[owner]=1 (request withdrawn) releases GNT and goes to TURN.
  - Otherwise the timer increments. When timer reaches GNT_TIMEOUT-1, release GNT, pulse timeout, go to TURN.
- OWNED: GNT is held while FRAME=0 or IRDY=0. On the first posedge with bus idle:
  - If any other REQ=0 or REQ[owner]=1, release GNT and go to TURN.
  - Else return to GRANTED with timer cleared. This is parking on the sole requester.
- TURN: all GNT high for exactly one clock, then IDLE. This guarantees one dead cycle between any two grants.
- Simultaneous requests: resolved only by the rotation order; lower index wins only when it comes next in rotation.
- A REQ released while in OWNED does not cut the transaction. The grant is released at bus idle.
- FRAME=0 seen while in IDLE or TURN (an illegal master) is ignored. No grant is issued until IDLE with the bus idle.
- IDLE additionally requires bus_idle=1 before granting.

## Timing
- Grant latency: REQ sampled low at posedge t in IDLE with the bus idle gives GNT low after edge t (1 clock, registered).
- GNT deassert to next GNT assert: minimum 2 clocks (the TURN cycle, then the IDLE grant).
- Timeout: GNT low for exactly GNT_TIMEOUT clocks when FRAME never falls.
- All outputs are registered. There is no combinational path from REQ, FRAME or IRDY to GNT.

## Structure
- Shared package pci_pkg:
  - arb_state_t enum (IDLE, GRANTED, OWNED, TURN).
  - Device address constants (0xAD, 0xBD, 0xCD).
  - C_BE command constants (write 4'b0100, read 4'b0001), so devices and arbiter share one source.
- Sub-module pci_rr_picker: combinational.
  - Inputs: REQ vector and last_owner.
  - Outputs: pick index and any_req.
  - Reusable and unit-testable in isolation.

## Test plan
- Reset, no requests: GNT=3'b111 and owner_valid=0 for 20 clocks. Assert rst_n=0 while GNT=3'b110: GNT returns to 3'b111 with no clock edge.
- REQ=3'b110 in IDLE: GNT=3'b110 one clock later. FRAME low 1 clock later, held 3 clocks, then FRAME and IRDY high with REQ=3'b111: GNT=3'b111 for TURN, then stays idle.
- REQ=3'b000 held, each master runs a 2-clock FRAME burst: grant order 0,1,2,0,1. At least one all-ones GNT cycle between consecutive grants.
- REQ[1]=0 alone, FRAME never asserted: GNT[1] low exactly 16 clocks, timeout pulses once, one TURN clock, then GNT[1] low again.
- Sole requester 2 keeps REQ low across two transactions: GNT[2] stays low through bus idle (parking, no TURN). REQ[0] falls during the second transaction: GNT[2] rises at the first idle edge, TURN, then GNT[0] falls.
- REQ[0] withdrawn while GRANTED before FRAME falls: GNT[0] rises next clock. A later FRAME=0 from master 0 with REQ[1]=0 pending gives no grant until the bus is idle again.

Source files
------------

// File: rtl/pci_pkg.sv
// -----------------------------------------------------------------------------
// pci_pkg
// Shared definitions for the PCI bus segment: the arbiter state encoding,
// target device addresses and the C/BE# bus commands. Devices and the arbiter
// both import this package so the encodings come from one place.
// -----------------------------------------------------------------------------
package pci_pkg;

    // Arbiter state machine encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        OWNED   = 2'd2,
        TURN    = 2'd3
    } arb_state_t;

    // Target device base addresses on this segment.
    localparam logic [7:0] DEV_ADDR_A = 8'hAD;
    localparam logic [7:0] DEV_ADDR_B = 8'hBD;
    localparam logic [7:0] DEV_ADDR_C = 8'hCD;

    // C/BE# command encodings used during the address phase.
    localparam logic [3:0] CBE_CMD_WRITE = 4'b0100;
    localparam logic [3:0] CBE_CMD_READ  = 4'b0001;

endpackage

// File: rtl/pci_rr_picker.sv
// -----------------------------------------------------------------------------
// pci_rr_picker
// Combinational round-robin selector. Starting one past last_owner and
// wrapping modulo NUM_MASTERS, returns the first index whose request is low.
//
// Ports:
//   req_n       in  NUM_MASTERS  per-master request, active low
//   last_owner  in  IDXW         index of the most recently granted master
//   pick        out IDXW         selected index (valid when any_req=1)
//   any_req     out 1            at least one request is low
// -----------------------------------------------------------------------------
module pci_rr_picker
    import pci_pkg::*;
#(
    parameter  int NUM_MASTERS = 3,
    localparam int IDXW        = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_n,
    input  logic [IDXW-1:0]        last_owner,
    output logic [IDXW-1:0]        pick,
    output logic                   any_req
);

    // Candidate k (k = 0..N-1) is the master at rotation distance k+1 from
    // last_owner; candidate 0 therefore has the highest priority.
    logic [NUM_MASTERS-1:0][IDXW-1:0] cand_idx;
    logic [NUM_MASTERS-1:0]           cand_valid;

    localparam logic [IDXW:0] N_WIDE = (IDXW+1)'(NUM_MASTERS);

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
            logic [IDXW:0] sum;
            logic [IDXW:0] wrapped;
            // last_owner < N and offset <= N, so one conditional subtract
            // is enough to wrap the sum back into range.
            assign sum           = {1'b0, last_owner} + (IDXW+1)'(gi + 1);
            assign wrapped       = (sum >= N_WIDE) ? (sum - N_WIDE) : sum;
            assign cand_idx[gi]  = wrapped[IDXW-1:0];
            assign cand_valid[gi] = ~req_n[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        pick = '0;
        // Walk from lowest priority to highest so the nearest candidate wins.
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                pick = cand_idx[k];
            end
        end
    end

    assign any_req = |cand_valid;

endmodule

// File: rtl/pci_arbiter.sv
// -----------------------------------------------------------------------------
// pci_arbiter
// Central round-robin arbiter for a shared PCI segment. Grants are issued only
// from IDLE with the bus idle, held across a transaction (FRAME#/IRDY#), parked
// on a sole requester, revoked after GNT_TIMEOUT clocks if the granted master
// never starts, and always separated by one dead TURN cycle.
//
// Ports:
//   clk          in  1            bus clock
//   rst_n        in  1            asynchronous reset, active low
//   REQ          in  NUM_MASTERS  per-master request, active low
//   FRAME        in  1            bus FRAME#, active low (sampled)
//   IRDY         in  1            bus IRDY#, active low (sampled)
//   GNT          out NUM_MASTERS  per-master grant, active low, one-cold
//   owner        out IDXW         index of granted master
//   owner_valid  out 1            a grant is currently asserted
//   bus_idle     out 1            FRAME#=1 and IRDY#=1 at last posedge
//   timeout      out 1            one-clock pulse on grant revocation by timer
// -----------------------------------------------------------------------------
module pci_arbiter
    import pci_pkg::*;
#(
    parameter  int NUM_MASTERS = 3,
    parameter  int GNT_TIMEOUT = 16,
    localparam int IDXW        = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] REQ,
    input  logic                   FRAME,
    input  logic                   IRDY,
    output logic [NUM_MASTERS-1:0] GNT,
    output logic [IDXW-1:0]        owner,
    output logic                   owner_valid,
    output logic                   bus_idle,
    output logic                   timeout
);

    localparam int              TW         = $clog2(GNT_TIMEOUT) + 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(GNT_TIMEOUT - 1);
    localparam logic [IDXW-1:0] LAST_RST   = IDXW'(NUM_MASTERS - 1);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDXW-1:0]        owner_q, owner_d;
    logic                   owner_valid_q, owner_valid_d;
    logic                   bus_idle_q, bus_idle_d;
    logic                   timeout_q, timeout_d;
    logic [IDXW-1:0]        last_owner_q, last_owner_d;
    logic [TW-1:0]          timer_q, timer_d;

    logic [IDXW-1:0]        pick;
    logic                   any_req;
    logic [NUM_MASTERS-1:0] pick_mask;
    logic [NUM_MASTERS-1:0] owner_mask;
    logic                   others_req;
    logic                   owner_req;

    pci_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req_n      (REQ),
        .last_owner (last_owner_q),
        .pick       (pick),
        .any_req    (any_req)
    );

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
            assign pick_mask[gi]  = (pick == IDXW'(gi));
            assign owner_mask[gi] = (owner_q == IDXW'(gi));
        end
    endgenerate

    // Another master wants the bus (the owner's own request is masked out).
    assign others_req = |(~REQ & ~owner_mask);
    assign owner_req  = ~REQ[owner_q];

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        bus_idle_d    = FRAME & IRDY;
        timeout_d     = 1'b0;
        last_owner_d  = last_owner_q;
        timer_d       = timer_q;

        unique case (state_q)
            IDLE: begin
                // A FRAME# from a rogue master leaves bus_idle_q low, which
                // holds off any grant until the bus has really gone idle.
                if (any_req && bus_idle_q) begin
                    gnt_d         = ~pick_mask;
                    owner_d       = pick;
                    owner_valid_d = 1'b1;
                    last_owner_d  = pick;
                    timer_d       = '0;
                    state_d       = GRANTED;
                end
            end

            GRANTED: begin
                if (!FRAME) begin
                    state_d = OWNED;
                end else if (!owner_req) begin
                    gnt_d         = '1;
                    owner_valid_d = 1'b0;
                    state_d       = TURN;
                end else if (timer_q == TIMER_LAST) begin
                    gnt_d         = '1;
                    owner_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                    state_d       = TURN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            OWNED: begin
                // Never cut a running transaction; decide only once idle.
                if (FRAME && IRDY) begin
                    if (others_req || !owner_req) begin
                        gnt_d         = '1;
                        owner_valid_d = 1'b0;
                        state_d       = TURN;
                    end else begin
                        // Park on the sole requester with a fresh timer.
                        timer_d = '0;
                        state_d = GRANTED;
                    end
                end
            end

            TURN: begin
                gnt_d   = '1;
                state_d = IDLE;
            end

            default: begin
                gnt_d         = '1;
                owner_valid_d = 1'b0;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '1;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            bus_idle_q    <= 1'b1;
            timeout_q     <= 1'b0;
            last_owner_q  <= LAST_RST;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            bus_idle_q    <= bus_idle_d;
            timeout_q     <= timeout_d;
            last_owner_q  <= last_owner_d;
            timer_q       <= timer_d;
        end
    end

    assign GNT         = gnt_q;
    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;
    assign bus_idle    = bus_idle_q;
    assign timeout     = timeout_q;

endmodule
